sr_drive_ctrl: RTL and testbench
================================

SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: consecutive stable-high cycles a synchronized request needs before it is accepted (range 1..255).
REQ-002 SHALL have parameter HOLD_CYCLES, default 3: lockout cycles after a completed command (range 0..255).
REQ-003 SHALL have parameter PRIO_SET, default 1: on simultaneous requests, 1 = set wins and 0 = clear wins.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port set_req, input, 1 bit: raw set request, asynchronous to clk.
REQ-007 SHALL have port clr_req, input, 1 bit: raw clear request, asynchronous to clk.
REQ-008 SHALL have port q_fb, input, 1 bit: q fed back from the downstream SR flip-flop.
REQ-009 SHALL have port s, output, 1 bit: set drive to the downstream SR flip-flop.
REQ-010 SHALL have port r, output, 1 bit: reset drive to the downstream SR flip-flop.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a command completes.
REQ-013 SHALL have port err, output, 1 bit: sticky feedback-mismatch flag; the port exists only when SR_DRIVE_CHECK_EN is defined.

Function
REQ-014 SHALL pass set_req and clr_req through 2-flop synchronizers; all logic uses the synchronized versions (set_s, clr_s).
REQ-015 SHALL implement states IDLE, DEBOUNCE, DRIVE, CHECK, HOLDOFF and WAIT_REL, all registered.
REQ-016 SHALL, in IDLE, move to DEBOUNCE when set_s or clr_s is high and latch the target: set if only set_s is high, clear if only clr_s is high, per PRIO_SET if both are high.
REQ-017 SHALL, in DEBOUNCE, count cycles in which the latched request stays high; after DEB_CYCLES such cycles, move to DRIVE; any drop resets the count and returns to IDLE.
REQ-018 SHALL skip DRIVE when the target already equals q_fb at debounce completion: go directly to HOLDOFF and still pulse done.
REQ-019 SHALL, in DRIVE, hold s (target set) or r (target clear) high for exactly one cycle; s and r SHALL never both be high in any cycle, including the reset release cycle.
REQ-020 SHALL, after DRIVE, go to CHECK for one cycle when SR_DRIVE_CHECK_EN is defined, otherwise directly to HOLDOFF.
REQ-021 SHALL pulse done for one cycle on every entry to HOLDOFF.
REQ-022 SHALL stay in HOLDOFF for HOLD_CYCLES cycles (HOLD_CYCLES=0 gives 1 pass-through cycle) and ignore requests there, then enter WAIT_REL.
REQ-023 SHALL stay in WAIT_REL until set_s and clr_s are both low, then return to IDLE; a held request never produces a second command.
REQ-024 SHALL use 8-bit saturating-free counters with terminal compare at DEB_CYCLES and HOLD_CYCLES; counters clear on every state entry.

Reset
REQ-025 SHALL, on rst assertion (including mid-DRIVE), immediately force s=0, r=0, done=0, busy=0 and err=0, set state to IDLE, and clear counters and synchronizers.
REQ-026 SHALL NOT act on requests until the synchronizers refill after rst deasserts (earliest DEBOUNCE entry: 3rd rising edge).

Configuration
REQ-027 SHALL, with SR_DRIVE_CHECK_EN defined, compare q_fb with the target in CHECK and set err on mismatch; err stays high until rst.
REQ-028 SHALL, without SR_DRIVE_CHECK_EN, omit the CHECK state, the err port and the compare logic.

Structure
REQ-029 SHALL place the state enum typedef, the target typedef (TGT_SET/TGT_CLR) and the parameter default constants in shared package sr_pkg.
REQ-030 SHALL instantiate sub-module sr_sync2 (2-flop synchronizer, clk/rst, 1 bit) once per request input.

Verification (DEB_CYCLES=4, HOLD_CYCLES=3, PRIO_SET=1, SR_DRIVE_CHECK_EN defined)
REQ-031 SHALL cover: set_req held high from q_fb=0 -> s=1 for exactly 1 cycle, 2 sync + 1 IDLE + 4 debounce cycles after the request, then done pulses, and no r or err.
REQ-032 SHALL cover: set_req and clr_req rising together -> only s pulses; rerun with PRIO_SET=0 -> only r pulses.
REQ-033 SHALL cover: set_req high for 3 synchronized cycles, then low -> no s, back in IDLE, busy low.
REQ-034 SHALL cover: clr_req while q_fb=0 -> no r pulse, done pulses once, then HOLDOFF.
REQ-035 SHALL cover: q_fb forced 0 after an s pulse -> err=1 and stays high until rst.
REQ-036 SHALL cover: rst asserted during DRIVE -> s=0 within the same cycle, state IDLE, busy=0.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared types and defaults for the SR flip-flop drive controller.
// Optional feature macro: SR_DRIVE_CHECK_EN adds the post-drive feedback CHECK state.
package sr_pkg;

  localparam int unsigned DEB_CYCLES_DEF  = 4;
  localparam int unsigned HOLD_CYCLES_DEF = 3;
  localparam bit          PRIO_SET_DEF    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_DRIVE    = 3'd2,
    ST_HOLDOFF  = 3'd3,
    ST_WAIT_REL = 3'd4
`ifdef SR_DRIVE_CHECK_EN
    ,
    ST_CHECK    = 3'd5
`endif
  } state_e;

  typedef enum logic {
    TGT_SET = 1'b0,
    TGT_CLR = 1'b1
  } tgt_e;

  // Resolve which command a pair of synchronized requests asks for.
  function automatic tgt_e pick_target(input logic set_s, input logic clr_s,
                                       input bit prio_set);
    if (set_s && clr_s) return prio_set ? TGT_SET : TGT_CLR;
    return set_s ? TGT_SET : TGT_CLR;
  endfunction

endpackage

// File: rtl/sr_sync2.sv
// Two-flop synchronizer for one asynchronous request line.
module sr_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops; both clear on reset so no stale request survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample old values, giving a true 2-stage delay.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Debounced set/clear command controller for a downstream SR flip-flop.
// Optional feature macro: SR_DRIVE_CHECK_EN (CHECK state, err port, feedback compare).
module sr_drive_ctrl
  import sr_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter bit          PRIO_SET    = PRIO_SET_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic done
`ifdef SR_DRIVE_CHECK_EN
  ,
  output logic err
`endif
);

  localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
  // HOLD_CYCLES of 0 still spends one pass-through cycle in HOLDOFF.
  localparam logic [7:0] HOLD_LAST = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);

  logic       set_s;
  logic       clr_s;
  state_e     state_q, state_d;
  tgt_e       tgt_q, tgt_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       req_held;
  logic       tgt_met;

  sr_sync2 u_sync_set (.clk(clk), .rst(rst), .d_i(set_req), .q_o(set_s));
  sr_sync2 u_sync_clr (.clk(clk), .rst(rst), .d_i(clr_req), .q_o(clr_s));

  // The latched request is still asserted, and the flop already holds the target value.
  assign req_held = (tgt_q == TGT_SET) ? set_s : clr_s;
  assign tgt_met  = (tgt_q == TGT_SET) ? q_fb  : ~q_fb;

  // Next-state logic; the counter clears on every state change by default.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (set_s || clr_s) begin
          state_d = ST_DEBOUNCE;
          tgt_d   = pick_target(set_s, clr_s, PRIO_SET);
        end
      end
      ST_DEBOUNCE: begin
        if (!req_held)               state_d = ST_IDLE;
        else if (cnt_q == DEB_LAST)  state_d = tgt_met ? ST_HOLDOFF : ST_DRIVE;
        else                         cnt_d   = cnt_q + 8'd1;
      end
      ST_DRIVE: begin
`ifdef SR_DRIVE_CHECK_EN
        state_d = ST_CHECK;
`else
        state_d = ST_HOLDOFF;
`endif
      end
`ifdef SR_DRIVE_CHECK_EN
      ST_CHECK: state_d = ST_HOLDOFF;
`endif
      ST_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) state_d = ST_WAIT_REL;
        else                    cnt_d   = cnt_q + 8'd1;
      end
      ST_WAIT_REL: begin
        if (!set_s && !clr_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_HOLDOFF) && (state_q != ST_HOLDOFF);
  end

  // State, target, counter and done pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tgt_q   <= TGT_SET;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef SR_DRIVE_CHECK_EN
  logic err_q;

  // Sticky mismatch flag: the flop did not follow the drive we just issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   err_q <= 1'b0;
    else if (state_q == ST_CHECK && !tgt_met)  err_q <= 1'b1;
  end

  assign err = err_q;
`endif

  // Drives decode from registered state only, so s and r are exclusive and drop with rst.
  assign s    = (state_q == ST_DRIVE) && (tgt_q == TGT_SET);
  assign r    = (state_q == ST_DRIVE) && (tgt_q == TGT_CLR);
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl: one PRIO_SET=1 instance and one PRIO_SET=0 instance.
module tb_sr_drive_ctrl;

`ifdef SR_DRIVE_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic clk = 1'b0;
  logic rst, set_req, clr_req;
  logic q1, q0, force0;
  logic s1, r1, busy1, done1;
  logic s0, r0, busy0, done0;
`ifdef SR_DRIVE_CHECK_EN
  logic err1, err0;
`endif

  int compared, mismatched;
  int cyc;
  int s1_cnt, r1_cnt, s1_at, done1_cnt, done1_at;
  int s0_cnt, r0_cnt, done0_cnt;
  int both_hi;

  always #5 clk = ~clk;

  sr_drive_ctrl #(.DEB_CYCLES(4), .HOLD_CYCLES(3), .PRIO_SET(1'b1)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_fb(q1),
    .s(s1), .r(r1), .busy(busy1), .done(done1)
`ifdef SR_DRIVE_CHECK_EN
    , .err(err1)
`endif
  );

  sr_drive_ctrl #(.DEB_CYCLES(4), .HOLD_CYCLES(3), .PRIO_SET(1'b0)) dut_c (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_fb(q0),
    .s(s0), .r(r0), .busy(busy0), .done(done0)
`ifdef SR_DRIVE_CHECK_EN
    , .err(err0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = 0;
    s1_cnt = 0; r1_cnt = 0; s1_at = 0; done1_cnt = 0; done1_at = 0;
    s0_cnt = 0; r0_cnt = 0; done0_cnt = 0;
  endtask

  // Advance n cycles, sampling on the falling edge and modelling both downstream SR flops.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (s1) begin s1_cnt++; if (s1_at == 0) s1_at = cyc; q1 = !force0; end
      if (r1) begin r1_cnt++; q1 = 1'b0; end
      if (done1) begin done1_cnt++; if (done1_at == 0) done1_at = cyc; end
      if (s0) begin s0_cnt++; q0 = 1'b1; end
      if (r0) begin r0_cnt++; q0 = 1'b0; end
      if (done0) done0_cnt++;
      if ((s1 && r1) || (s0 && r0)) both_hi++;
    end
  endtask

  initial begin
    compared = 0; mismatched = 0; both_hi = 0;
    rst = 1'b1; set_req = 1'b0; clr_req = 1'b0;
    q1 = 1'b0; q0 = 1'b0; force0 = 1'b0;
    clear_mon();

    // Reset state
    tick(2);
    check("rst_s", s1, 0);
    check("rst_r", r1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
`ifdef SR_DRIVE_CHECK_EN
    check("rst_err", err1, 0);
`endif

    // Set request from q_fb=0, raised together with reset release
    clear_mon();
    rst = 1'b0; set_req = 1'b1;
    tick(2);
    check("set_sync_idle_busy", busy1, 0);
    tick(1);
    check("set_debounce_busy", busy1, 1);
    tick(3);
    check("set_no_early_s", s1, 0);
    tick(1);
    check("set_s_cycle7", s1, 1);
    check("set_r_cycle7", r1, 0);
    tick(9);
    check("set_s_count", s1_cnt, 1);
    check("set_s_at", s1_at, 7);
    check("set_r_count", r1_cnt, 0);
    check("set_done_count", done1_cnt, 1);
    check("set_done_at", done1_at, 8 + CHK);
    check("set_held_busy", busy1, 1);
`ifdef SR_DRIVE_CHECK_EN
    check("set_err", err1, 0);
`endif
    set_req = 1'b0;
    tick(2);
    check("set_rel_busy_wait", busy1, 1);
    tick(1);
    check("set_rel_busy_idle", busy1, 0);

    // Simultaneous requests: set wins on dut, clear wins on dut_c
    clear_mon();
    q1 = 1'b0; q0 = 1'b1;
    set_req = 1'b1; clr_req = 1'b1;
    tick(16);
    check("both_p1_s", s1_cnt, 1);
    check("both_p1_r", r1_cnt, 0);
    check("both_p0_s", s0_cnt, 0);
    check("both_p0_r", r0_cnt, 1);
    check("both_p1_done", done1_cnt, 1);
    check("both_p0_done", done0_cnt, 1);
    set_req = 1'b0; clr_req = 1'b0;
    tick(3);
    check("both_rel_busy1", busy1, 0);
    check("both_rel_busy0", busy0, 0);

    // Short set request: three synchronized high cycles then drop
    clear_mon();
    set_req = 1'b1;
    tick(3);
    check("short_busy_mid", busy1, 1);
    set_req = 1'b0;
    tick(5);
    check("short_busy_end", busy1, 0);
    check("short_s_count", s1_cnt, 0);
    check("short_done_count", done1_cnt, 0);

    // Clear request while q_fb already 0: no drive, done still pulses
    clear_mon();
    q1 = 1'b0; q0 = 1'b0;
    clr_req = 1'b1;
    tick(7);
    check("clr_skip_done", done1, 1);
    check("clr_skip_busy", busy1, 1);
    check("clr_skip_r_now", r1, 0);
    tick(1);
    check("clr_skip_done_drop", done1, 0);
    check("clr_skip_holdoff_busy", busy1, 1);
    tick(8);
    check("clr_skip_r_count", r1_cnt, 0);
    check("clr_skip_done_count", done1_cnt, 1);
    clr_req = 1'b0;
    tick(3);
    check("clr_rel_busy", busy1, 0);

`ifdef SR_DRIVE_CHECK_EN
    // Feedback stuck at 0 after the set drive: sticky err
    clear_mon();
    q1 = 1'b0; force0 = 1'b1;
    set_req = 1'b1;
    tick(16);
    check("err_s_count", s1_cnt, 1);
    check("err_set", err1, 1);
    set_req = 1'b0;
    tick(3);
    check("err_sticky", err1, 1);
    check("err_rel_busy", busy1, 0);
    force0 = 1'b0;
`endif

    // Reset asserted during DRIVE
    clear_mon();
    q1 = 1'b0;
    set_req = 1'b1;
    tick(7);
    check("rstdrv_s_before", s1, 1);
    rst = 1'b1;
    #1;
    check("rstdrv_s", s1, 0);
    check("rstdrv_r", r1, 0);
    check("rstdrv_busy", busy1, 0);
    check("rstdrv_done", done1, 0);
`ifdef SR_DRIVE_CHECK_EN
    check("rstdrv_err", err1, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    check("rstrel_sync_busy", busy1, 0);
    tick(1);
    check("rstrel_debounce_busy", busy1, 1);
    set_req = 1'b0;
    tick(4);

    check("never_s_and_r", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
